// File: rtl/adder_operand_seq_pkg.sv
// adder_operand_seq_pkg: shared state encodings, display slot numbers and ASCII labels
package adder_operand_seq_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_OP1 = 2'd0,
      ST_WAIT_OP2 = 2'd1,
      ST_CALC     = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   localparam logic [5:0] SLOT_OP1   = 6'd1;
   localparam logic [5:0] SLOT_OP2   = 6'd3;
   localparam logic [5:0] SLOT_RES   = 6'd5;
   localparam logic [5:0] SLOT_COUT  = 6'd7;
   localparam logic [5:0] SLOT_COUNT = 6'd9;
   localparam logic [5:0] SLOT_STATE = 6'd11;

   localparam logic [39:0] LBL_OP1   = "ADD_1";
   localparam logic [39:0] LBL_OP2   = "ADD_2";
   localparam logic [39:0] LBL_RES   = "RESUL";
   localparam logic [39:0] LBL_COUT  = "COUT ";
   localparam logic [39:0] LBL_COUNT = "COUNT";
   localparam logic [39:0] LBL_STATE = "STATE";

endpackage

// File: rtl/adder_operand_seq_edge_strobe.sv
// adder_operand_seq_edge_strobe: one-cycle pulse on each rising edge of a level input
module adder_operand_seq_edge_strobe (
   input  logic clk,
   input  logic resetn,
   input  logic level_i,
   output logic pulse_o
);

   logic prev_q;

   // remember last cycle's level so a held input yields a single pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) prev_q <= 1'b0;
      else         prev_q <= level_i;
   end

   assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/adder_operand_seq.sv
// adder_operand_seq: captures two touch entries as adder operands, registers the sum and drives the LCD slot mux
module adder_operand_seq
   import adder_operand_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 10_000_000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        input_valid,
   input  logic [31:0] input_value,
   input  logic        sw_cin,
   input  logic        clear,
   output logic [31:0] adder_op1,
   output logic [31:0] adder_op2,
   output logic        adder_cin,
   input  logic [31:0] adder_res,
   input  logic        adder_cout,
   output logic        led_cout,
   output logic [1:0]  led_state,
   input  logic [5:0]  display_number,
   output logic        display_valid,
   output logic [39:0] display_name,
   output logic [31:0] display_value
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e          state_q;
   logic [31:0]     op1_q, op2_q, result_q;
   logic            cin_q, cout_q;
   logic [CNT_W-1:0] count_q;
   logic [TW-1:0]   timer_q;
   logic            strobe, timer_hit;
   logic            disp_valid_d, disp_valid_q;
   logic [39:0]     disp_name_d, disp_name_q;
   logic [31:0]     disp_value_d, disp_value_q;

   adder_operand_seq_edge_strobe u_strobe (
      .clk     (clk),
      .resetn  (resetn),
      .level_i (input_valid),
      .pulse_o (strobe)
   );

   assign timer_hit = (TIMEOUT != 0) && (timer_q == T_LAST);

   // operand capture / calc / done sequencing; clear beats strobe and timeout
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_WAIT_OP1;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         cin_q    <= 1'b0;
         cout_q   <= 1'b0;
         count_q  <= '0;
         timer_q  <= '0;
      end else if (clear) begin
         state_q  <= ST_WAIT_OP1;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         cin_q    <= 1'b0;
         cout_q   <= 1'b0;
         count_q  <= '0;
         timer_q  <= '0;
      end else begin
         case (state_q)
            ST_WAIT_OP1, ST_DONE: if (strobe) begin
               op1_q   <= input_value;
               timer_q <= '0;
               state_q <= ST_WAIT_OP2;
            end
            ST_WAIT_OP2: if (strobe) begin
               op2_q   <= input_value;
               cin_q   <= sw_cin;
               state_q <= ST_CALC;
            end else if (timer_hit) begin
               state_q <= ST_WAIT_OP1;
            end else begin
               timer_q <= timer_q + TW'(1);
            end
            ST_CALC: begin
               result_q <= adder_res;
               cout_q   <= adder_cout;
               count_q  <= count_q + CNT_W'(1);
               state_q  <= ST_DONE;
            end
            default: state_q <= ST_WAIT_OP1;
         endcase
      end
   end

   // slot lookup for the LCD; unknown slots report invalid with blank label/value
   always_comb begin
      disp_valid_d = 1'b1;
      disp_name_d  = '0;
      disp_value_d = '0;
      case (display_number)
         SLOT_OP1:   begin disp_name_d = LBL_OP1;   disp_value_d = op1_q;              end
         SLOT_OP2:   begin disp_name_d = LBL_OP2;   disp_value_d = op2_q;              end
         SLOT_RES:   begin disp_name_d = LBL_RES;   disp_value_d = result_q;           end
         SLOT_COUT:  begin disp_name_d = LBL_COUT;  disp_value_d = {31'b0, cout_q};    end
         SLOT_COUNT: begin disp_name_d = LBL_COUNT; disp_value_d = 32'(count_q);       end
         SLOT_STATE: begin disp_name_d = LBL_STATE; disp_value_d = {30'b0, state_q};   end
         default:    disp_valid_d = 1'b0;
      endcase
   end

   // display outputs registered; clear leaves them alone
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disp_valid_q <= 1'b0;
         disp_name_q  <= '0;
         disp_value_q <= '0;
      end else begin
         disp_valid_q <= disp_valid_d;
         disp_name_q  <= disp_name_d;
         disp_value_q <= disp_value_d;
      end
   end

   assign adder_op1     = op1_q;
   assign adder_op2     = op2_q;
   assign adder_cin     = cin_q;
   assign led_cout      = cout_q;
   assign led_state     = state_q;
   assign display_valid = disp_valid_q;
   assign display_name  = disp_name_q;
   assign display_value = disp_value_q;

endmodule
